// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: state packing, round count, controller FSM
// encoding and the round-key index mapping.
package aes_pkg;

    localparam int NR       = 10;
    localparam int RK_IDX_W = 4;

    // Element [0] is column 0; bits [31:24] of a column are row 0.
    typedef logic [0:3][31:0]     aes_state_t;
    typedef logic [RK_IDX_W-1:0]  rk_idx_t;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        ROUND,
        FINAL,
        DONE
    } aes_fsm_e;

    // Encryption walks the key schedule upwards, decryption downwards.
    function automatic rk_idx_t rk_index(input rk_idx_t round, input logic dec);
        return dec ? (rk_idx_t'(NR) - round) : round;
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Block handshake, key-schedule and round-datapath signals of the AES
// round sequencer, bundled with controller and environment views.
interface aes_round_ctrl_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    aes_state_t data_i;
    logic       enc_dec_i;
    logic       out_valid;
    logic       out_ready;
    aes_state_t data_o;
    rk_idx_t    rk_idx;
    logic       rk_valid;
    aes_state_t rd_state_o;
    aes_state_t rd_state_i;
    logic       rd_enc_dec;
    logic       rd_ark_only;
    logic       rd_skip_mix;
    rk_idx_t    round_o;
    logic       busy;

    modport slave (
        input  in_valid, data_i, enc_dec_i, out_ready, rk_valid, rd_state_i,
        output in_ready, out_valid, data_o, rk_idx, rd_state_o,
               rd_enc_dec, rd_ark_only, rd_skip_mix, round_o, busy
    );

    modport master (
        output in_valid, data_i, enc_dec_i, out_ready, rk_valid, rd_state_i,
        input  in_ready, out_valid, data_o, rk_idx, rd_state_o,
               rd_enc_dec, rd_ark_only, rd_skip_mix, round_o, busy
    );

endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round sequencer: owns the state register and steps the
// external round datapath through the initial key add, NR-1 rounds and the final round.
module aes_round_ctrl
    import aes_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    aes_round_ctrl_if.slave   bus
);

    aes_fsm_e   fsm_q, fsm_d;
    aes_state_t st_q, st_d;
    logic       dec_q, dec_d;
    rk_idx_t    round_q, round_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            st_q    <= '0;
            dec_q   <= 1'b0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            st_q    <= st_d;
            dec_q   <= dec_d;
            round_q <= round_d;
        end
    end

    // Every pass waits on rk_valid; a missing key freezes the whole sequencer.
    always_comb begin
        fsm_d   = fsm_q;
        st_d    = st_q;
        dec_d   = dec_q;
        round_d = round_q;
        unique case (fsm_q)
            IDLE: begin
                if (bus.in_valid) begin
                    st_d    = bus.data_i;
                    dec_d   = bus.enc_dec_i;
                    round_d = '0;
                    fsm_d   = INIT;
                end
            end
            INIT: begin
                if (bus.rk_valid) begin
                    st_d    = bus.rd_state_i;
                    round_d = rk_idx_t'(1);
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                if (bus.rk_valid) begin
                    st_d    = bus.rd_state_i;
                    round_d = round_q + rk_idx_t'(1);
                    if (round_q == rk_idx_t'(NR - 1)) begin
                        fsm_d = FINAL;
                    end
                end
            end
            FINAL: begin
                if (bus.rk_valid) begin
                    st_d  = bus.rd_state_i;
                    fsm_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // All outputs decode registered state only, so handshakes have no input-to-output path.
    always_comb begin
        bus.in_ready    = (fsm_q == IDLE);
        bus.out_valid   = (fsm_q == DONE);
        bus.busy        = (fsm_q == INIT) || (fsm_q == ROUND) || (fsm_q == FINAL);
        bus.data_o      = (fsm_q == DONE) ? st_q : '0;
        bus.rd_state_o  = st_q;
        bus.rd_enc_dec  = dec_q;
        bus.rd_ark_only = (fsm_q == INIT);
        bus.rd_skip_mix = (fsm_q == FINAL);
        bus.round_o     = round_q;
        bus.rk_idx      = rk_index(round_q, dec_q);
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: supplies an AES round datapath and key
// schedule, drives random blocks/stalls/back-pressure and compares with a full-cipher model.
module tb_aes_round_ctrl;
    import aes_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_round_ctrl_if bus ();

    aes_round_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    localparam aes_state_t   VEC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam aes_state_t   VEC_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] VEC_KEY = 128'h000102030405060708090a0b0c0d0e0f;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox     [256];
    logic [7:0] inv_sbox [256];
    aes_state_t rk_tbl   [16];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- GF(2^8) and AES primitives ----------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        for (int x = 0; x < 256; x++) begin
            xb  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            inv_sbox[sbox[x]] = xb;
        end
    endtask

    function automatic logic [7:0] gb(input aes_state_t s, input int r, input int c);
        return s[c][31-8*r -: 8];
    endfunction

    function automatic aes_state_t sub_bytes(input aes_state_t s, input logic inv);
        aes_state_t t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[c][31-8*r -: 8] = inv ? inv_sbox[gb(s, r, c)] : sbox[gb(s, r, c)];
        return t;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s, input logic inv);
        aes_state_t t;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[c][31-8*r -: 8] = gb(s, r, inv ? (c - r + 4) % 4 : (c + r) % 4);
        return t;
    endfunction

    function automatic aes_state_t mix_columns(input aes_state_t s, input logic inv);
        aes_state_t t;
        logic [7:0] cf [4];
        logic [7:0] acc;
        if (inv) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(cf[(k - r + 4) % 4], gb(s, k, c));
                t[c][31-8*r -: 8] = acc;
            end
        return t;
    endfunction

    task automatic load_key(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
                rcon = xtime(rcon);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tbl[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
    endtask

    // One datapath pass as the external aes_round unit would perform it.
    function automatic aes_state_t dp_pass(input aes_state_t s, input aes_state_t k,
                                           input logic dec, input logic ark_only, input logic skip_mix);
        aes_state_t t;
        if (ark_only) return s ^ k;
        if (!dec) begin
            t = shift_rows(sub_bytes(s, 1'b0), 1'b0);
            if (!skip_mix) t = mix_columns(t, 1'b0);
            return t ^ k;
        end
        t = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
        if (!skip_mix) t = mix_columns(t, 1'b1);
        return t;
    endfunction

    // Whole-block reference cipher.
    function automatic aes_state_t ref_cipher(input aes_state_t blk, input logic dec);
        aes_state_t s;
        if (!dec) begin
            s = blk ^ rk_tbl[0];
            for (int r = 1; r < NR; r++)
                s = mix_columns(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk_tbl[r];
            s = shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk_tbl[NR];
        end else begin
            s = blk ^ rk_tbl[NR];
            for (int r = NR - 1; r >= 1; r--)
                s = mix_columns(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_tbl[r], 1'b1);
            s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk_tbl[0];
        end
        return s;
    endfunction

    always @(negedge clk)
        bus.rd_state_i = dp_pass(bus.rd_state_o, rk_tbl[bus.rk_idx], bus.rd_enc_dec,
                                 bus.rd_ark_only, bus.rd_skip_mix);

    // ---------------- one block through the controller ----------------
    task automatic do_block(input aes_state_t blk, input logic dec, input int stall_round,
                            input int stall_len, input bit rnd_stall, input bit noise,
                            input int bp_len, output aes_state_t res, output int lat);
        int         lows;
        int         stall_left;
        bit         held;
        bit         timed_out;
        rk_idx_t    prev_idx;
        rk_idx_t    prev_round;
        aes_state_t prev_st;
        rk_idx_t    seq [$];
        lows = 0; stall_left = stall_len; held = 0; timed_out = 1;
        prev_idx = '0; prev_round = '0; prev_st = '0;

        @(negedge clk);
        for (int g = 0; g < 50 && !bus.in_ready; g++) @(negedge clk);
        check_eq("in_ready_before_accept", 128'(bus.in_ready), 128'(1));
        bus.in_valid  = 1'b1;
        bus.data_i    = blk;
        bus.enc_dec_i = dec;
        bus.rk_valid  = 1'b1;
        @(posedge clk);
        lat = 0;
        for (int g = 0; g < 200; g++) begin
            @(negedge clk);
            if (held) begin
                check_eq("stall_round_hold", 128'(bus.round_o), 128'(prev_round));
                check_eq("stall_state_hold", bus.rd_state_o, prev_st);
                check_eq("stall_rkidx_hold", 128'(bus.rk_idx), 128'(prev_idx));
                held = 0;
            end
            if (bus.out_valid) begin
                timed_out = 0;
                break;
            end
            if (noise) begin
                bus.in_valid  = 1'b1;
                bus.data_i    = {$urandom, $urandom, $urandom, $urandom};
                bus.enc_dec_i = ~dec;
            end else begin
                bus.in_valid  = 1'b0;
            end
            check_eq("busy", 128'(bus.busy), 128'(1));
            check_eq("in_ready_busy", 128'(bus.in_ready), 128'(0));
            check_eq("dir_latched", 128'(bus.rd_enc_dec), 128'(dec));
            check_eq("ark_only", 128'(bus.rd_ark_only), 128'(bus.round_o == 4'd0));
            check_eq("skip_mix", 128'(bus.rd_skip_mix), 128'(bus.round_o == 4'(NR)));
            if (int'(bus.round_o) == stall_round && stall_left > 0) begin
                bus.rk_valid = 1'b0;
                stall_left--;
            end else if (rnd_stall) begin
                bus.rk_valid = ($urandom_range(0, 3) != 0);
            end else begin
                bus.rk_valid = 1'b1;
            end
            if (!bus.rk_valid) begin
                lows++;
                held       = 1;
                prev_round = bus.round_o;
                prev_st    = bus.rd_state_o;
                prev_idx   = bus.rk_idx;
            end else begin
                seq.push_back(bus.rk_idx);
            end
            lat++;
        end
        check_eq("timeout", 128'(timed_out), 128'(0));
        check_eq("latency", 128'(lat), 128'(11 + lows));
        res = bus.data_o;
        check_eq("result_vs_model", res, ref_cipher(blk, dec));
        check_eq("rk_seq_len", 128'(seq.size()), 128'(NR + 1));
        foreach (seq[i]) check_eq("rk_seq", 128'(seq[i]), 128'(dec ? NR - i : i));

        for (int i = 0; i < bp_len; i++) begin
            check_eq("bp_out_valid", 128'(bus.out_valid), 128'(1));
            check_eq("bp_data_stable", bus.data_o, res);
            check_eq("bp_in_ready", 128'(bus.in_ready), 128'(0));
            @(negedge clk);
        end
        check_eq("done_out_valid", 128'(bus.out_valid), 128'(1));
        check_eq("done_data", bus.data_o, res);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq("post_hs_in_ready", 128'(bus.in_ready), 128'(1));
        check_eq("post_hs_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("post_hs_not_accepted", 128'(bus.busy), 128'(0));
        bus.in_valid = 1'b0;
    endtask

    initial begin
        aes_state_t res;
        aes_state_t res2;
        aes_state_t blk;
        int         lat;
        bit         seen;
        logic       dec;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.data_i    = '0;
        bus.enc_dec_i = 1'b0;
        bus.out_ready = 1'b0;
        bus.rk_valid  = 1'b1;
        build_sbox();
        load_key(VEC_KEY);

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready", 128'(bus.in_ready), 128'(1));
        check_eq("rst_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("rst_data_o", bus.data_o, '0);
        check_eq("rst_state", bus.rd_state_o, '0);
        check_eq("rst_round", 128'(bus.round_o), 128'(0));
        check_eq("rst_rk_idx", 128'(bus.rk_idx), 128'(0));
        check_eq("rst_busy", 128'(bus.busy), 128'(0));
        check_eq("rst_enc_dec", 128'(bus.rd_enc_dec), 128'(0));
        rst = 1'b0;

        // ---------------- directed vectors ----------------
        do_block(VEC_PT, 1'b0, -1, 0, 1'b0, 1'b0, 0, res, lat);
        check_eq("enc_vector", res, VEC_CT);
        check_eq("enc_latency", 128'(lat), 128'(11));

        do_block(VEC_CT, 1'b1, -1, 0, 1'b0, 1'b0, 0, res, lat);
        check_eq("dec_vector", res, VEC_PT);
        check_eq("dec_latency", 128'(lat), 128'(11));

        do_block(VEC_PT, 1'b0, 5, 3, 1'b0, 1'b0, 0, res, lat);
        check_eq("stall_vector", res, VEC_CT);
        check_eq("stall_latency", 128'(lat), 128'(14));

        do_block(VEC_PT, 1'b0, -1, 0, 1'b0, 1'b0, 4, res, lat);
        check_eq("bp_vector", res, VEC_CT);

        // ---------------- reset mid-run ----------------
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.data_i    = VEC_PT;
        bus.enc_dec_i = 1'b0;
        bus.rk_valid  = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
        for (int g = 0; g < 30 && bus.round_o != 4'd6; g++) @(negedge clk);
        check_eq("abort_at_round6", 128'(bus.round_o), 128'(6));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_in_ready", 128'(bus.in_ready), 128'(1));
        check_eq("abort_out_valid", 128'(bus.out_valid), 128'(0));
        check_eq("abort_round", 128'(bus.round_o), 128'(0));
        check_eq("abort_busy", 128'(bus.busy), 128'(0));
        check_eq("abort_state", bus.rd_state_o, '0);
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1;
        end
        check_eq("abort_no_out_valid", 128'(seen), 128'(0));
        do_block(VEC_PT, 1'b0, -1, 0, 1'b0, 1'b0, 0, res, lat);
        check_eq("post_abort_vector", res, VEC_CT);

        // ---------------- inputs ignored while busy ----------------
        do_block(VEC_PT, 1'b0, -1, 0, 1'b0, 1'b1, 2, res, lat);
        check_eq("noise_enc_vector", res, VEC_CT);
        do_block(VEC_CT, 1'b1, -1, 0, 1'b1, 1'b1, 1, res, lat);
        check_eq("noise_dec_vector", res, VEC_PT);

        // ---------------- randomized keys, blocks, stalls, back-pressure ----------------
        for (int t = 0; t < 24; t++) begin
            load_key({$urandom, $urandom, $urandom, $urandom});
            blk = {$urandom, $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            do_block(blk, dec, -1, 0, 1'b1, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), res, lat);
            do_block(res, ~dec, -1, 0, 1'b1, 1'($urandom_range(0, 1)),
                     $urandom_range(0, 3), res2, lat);
            check_eq("roundtrip", res2, blk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
